// File: rtl/traffic_light_ctrl_pkg.sv
// traffic_light_ctrl_pkg: state codes, lamp encodings and lamp decode shared by the intersection controller.
package traffic_light_ctrl_pkg;
   typedef enum logic [2:0] {
      A_GRN    = 3'd0,
      A_YEL    = 3'd1,
      RED_AB   = 3'd2,
      B_GRN    = 3'd3,
      B_YEL    = 3'd4,
      RED_BA   = 3'd5,
      PED_WALK = 3'd6
   } state_e;
   localparam logic [1:0] LAMP_GRN = 2'b00;
   localparam logic [1:0] LAMP_YEL = 2'b01;
   localparam logic [1:0] LAMP_RED = 2'b10;
   function automatic logic [1:0] lamp(input state_e s, input state_e grn, input state_e yel);
      return s == grn ? LAMP_GRN : s == yel ? LAMP_YEL : LAMP_RED;
   endfunction
endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// traffic_light_ctrl_phase_timer: saturating phase timer with synchronous clear and async active-low reset.
module traffic_light_ctrl_phase_timer #(
   parameter int CNT_W = 4
) (
   input  logic             CLK,
   input  logic             RESETB,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt
);
   logic [CNT_W-1:0] r_cnt;
   always_ff @(posedge CLK or negedge RESETB)
      if (!RESETB) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (~&r_cnt) r_cnt <= r_cnt + 1'b1;
   assign o_cnt = r_cnt;
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: timed two-road light controller with min/max green, clearance and pedestrian WALK.
module traffic_light_ctrl
   import traffic_light_ctrl_pkg::*;
#(
   parameter int CNT_W         = 4,
   parameter int MIN_GREEN_CYC = 4,
   parameter int MAX_GREEN_CYC = 12,
   parameter int YELLOW_CYC    = 3,
   parameter int ALL_RED_CYC   = 2,
   parameter int WALK_CYC      = 5
) (
   input  logic       CLK,
   input  logic       RESETB,
   input  logic       TA,
   input  logic       TB,
   input  logic       PED_REQ,
   output logic [1:0] LA,
   output logic [1:0] LB,
   output logic       WALK,
   output logic [2:0] STATE
);
   localparam int MAXV = 2 ** CNT_W - 1;
   if (MIN_GREEN_CYC < 1 || YELLOW_CYC < 1 || ALL_RED_CYC < 1 || WALK_CYC < 1 ||
       MAX_GREEN_CYC > MAXV || YELLOW_CYC > MAXV || ALL_RED_CYC > MAXV || WALK_CYC > MAXV ||
       MAX_GREEN_CYC <= MIN_GREEN_CYC) begin : g_bad_params
      $error("traffic_light_ctrl: illegal timing parameters");
   end
   localparam logic [CNT_W-1:0] MIN_T  = CNT_W'(MIN_GREEN_CYC - 1);
   localparam logic [CNT_W-1:0] MAX_T  = CNT_W'(MAX_GREEN_CYC - 1);
   localparam logic [CNT_W-1:0] YEL_T  = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] RED_T  = CNT_W'(ALL_RED_CYC - 1);
   localparam logic [CNT_W-1:0] WALK_T = CNT_W'(WALK_CYC - 1);
   state_e           r_state, w_nxt;
   logic [CNT_W-1:0] w_timer;
   logic             r_ped, r_nxt_b, w_enter_walk;
   traffic_light_ctrl_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .CLK(CLK), .RESETB(RESETB), .i_clr(w_nxt != r_state), .o_cnt(w_timer)
   );
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         A_GRN:    w_nxt = w_timer >= MIN_T && (r_ped || !TA || (TB && w_timer >= MAX_T)) ? A_YEL : A_GRN;
         A_YEL:    w_nxt = w_timer == YEL_T ? (r_ped ? PED_WALK : RED_AB) : A_YEL;
         RED_AB:   w_nxt = w_timer == RED_T ? B_GRN : RED_AB;
         B_GRN:    w_nxt = w_timer >= MIN_T && (r_ped || !TB || (TA && w_timer >= MAX_T)) ? B_YEL : B_GRN;
         B_YEL:    w_nxt = w_timer == YEL_T ? (r_ped ? PED_WALK : RED_BA) : B_YEL;
         RED_BA:   w_nxt = w_timer == RED_T ? A_GRN : RED_BA;
         PED_WALK: w_nxt = w_timer == WALK_T ? (r_nxt_b ? B_GRN : A_GRN) : PED_WALK;
         default:  w_nxt = A_GRN;
      endcase
   end
   assign w_enter_walk = w_nxt == PED_WALK && r_state != PED_WALK;
   // Outputs are decoded from the next state so they change on the same edge as r_state.
   always_ff @(posedge CLK or negedge RESETB)
      if (!RESETB) begin
         r_state <= A_GRN;
         r_ped   <= 1'b0;
         r_nxt_b <= 1'b1;
         LA      <= LAMP_GRN;
         LB      <= LAMP_RED;
         WALK    <= 1'b0;
         STATE   <= 3'd0;
      end else begin
         r_state <= w_nxt;
         r_ped   <= w_enter_walk ? 1'b0 : r_ped | (PED_REQ && r_state != PED_WALK);
         if (w_enter_walk) r_nxt_b <= r_state == A_YEL;
         LA      <= lamp(w_nxt, A_GRN, A_YEL);
         LB      <= lamp(w_nxt, B_GRN, B_YEL);
         WALK    <= w_nxt == PED_WALK;
         STATE   <= w_nxt;
      end
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: random and directed stimulus scored against a phase-table model of the intersection.
module tb_traffic_light_ctrl;
   localparam int MIN = 4, MAX = 12, YEL = 3, AR = 2, WLK = 5;
   logic       CLK = 1'b0, RESETB = 1'b1, TA = 1'b0, TB = 1'b0, PED_REQ = 1'b0;
   logic [1:0] LA, LB;
   logic       WALK;
   logic [2:0] STATE;
   int         tests = 0, fails = 0;
   logic [7:0] q[$];
   // Phases 0..6: A green, A yellow, red A->B, B green, B yellow, red B->A, walk.
   int         dur[7]   = '{0, YEL, AR, 0, YEL, AR, WLK};
   logic [1:0] la_of[7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
   logic [1:0] lb_of[7] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd2};
   int         m_p, m_n;
   bit         m_ped, m_nb;

   traffic_light_ctrl #(
      .CNT_W(4), .MIN_GREEN_CYC(MIN), .MAX_GREEN_CYC(MAX),
      .YELLOW_CYC(YEL), .ALL_RED_CYC(AR), .WALK_CYC(WLK)
   ) dut (
      .CLK(CLK), .RESETB(RESETB), .TA(TA), .TB(TB), .PED_REQ(PED_REQ),
      .LA(LA), .LB(LB), .WALK(WALK), .STATE(STATE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   task automatic model_reset();
      m_p = 0; m_n = 0; m_ped = 0; m_nb = 1;
   endtask

   // Drive one cycle of inputs at a negedge, predict the state after the next rising edge.
   task automatic step(input bit ta, input bit tb, input bit pr);
      int nxt, n;
      bit own, oth;
      TA = ta; TB = tb; PED_REQ = pr;
      n = m_n + 1;
      nxt = m_p;
      own = m_p == 0 ? ta : tb;
      oth = m_p == 0 ? tb : ta;
      if (m_p == 0 || m_p == 3) begin
         if (n >= MIN && (m_ped || !own || (oth && n >= MAX))) nxt = m_p + 1;
      end else if (n == dur[m_p]) begin
         if (m_p == 6) nxt = m_nb ? 3 : 0;
         else if (m_p == 1 || m_p == 4) begin
            if (m_ped) begin
               nxt = 6;
               m_nb = m_p == 1;
            end else nxt = m_p + 1;
         end else nxt = m_p == 2 ? 3 : 0;
      end
      if (m_p != 6) m_ped = nxt == 6 ? 1'b0 : (m_ped | pr);
      m_n = nxt == m_p ? m_n + 1 : 0;
      m_p = nxt;
      q.push_back({la_of[m_p], lb_of[m_p], m_p == 6, 3'(m_p)});
      @(negedge CLK);
   endtask

   always @(posedge CLK) begin
      logic [7:0] e;
      #1;
      if (RESETB && q.size() > 0) begin
         e = q.pop_front();
         tests++;
         if ({LA, LB, WALK, STATE} != e) begin
            fails++;
            $display("FAIL out t=%0t got LA=%0d LB=%0d WALK=%0d STATE=%0d exp LA=%0d LB=%0d WALK=%0d STATE=%0d",
                     $time, LA, LB, WALK, STATE, e[7:6], e[5:4], e[3], e[2:0]);
         end
         tests++;
         if (LA != 2'd2 && LB != 2'd2) begin
            fails++;
            $display("FAIL both_nonred got LA=%0d LB=%0d exp one red", LA, LB);
         end
      end
   end

   initial begin
      model_reset();
      #1 RESETB = 1'b0;
      #2;
      chk("rst_LA", LA, 0); chk("rst_LB", LB, 2); chk("rst_WALK", WALK, 0); chk("rst_STATE", STATE, 0);
      @(negedge CLK);
      RESETB = 1'b1;
      repeat (12) step(1'b0, 1'b1, 1'b0);
      repeat (100) step(1'b1, 1'b0, 1'b0);
      repeat (40) step(1'b1, 1'b1, 1'b0);
      repeat (30) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      repeat (6) step(1'b1, 1'b0, 1'b0);
      repeat (6) step(1'b1, 1'b0, 1'b1);
      repeat (30) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      for (int i = 0; i < 60 && !(m_p == 0 && m_n >= 1); i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 20 && m_p != 1; i++) step(1'b1, 1'b0, 1'b0);
      chk("reach_A_YEL", m_p, 1);
      #2 RESETB = 1'b0;
      #1;
      chk("arst_LA", LA, 0); chk("arst_LB", LB, 2); chk("arst_WALK", WALK, 0); chk("arst_STATE", STATE, 0);
      q.delete();
      model_reset();
      @(negedge CLK);
      RESETB = 1'b1;
      repeat (30) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 200; i++)
         step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 9) == 0);
      #2;
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
